sfq_pipelined_adder: RTL and testbench
======================================

Name: sfq_pipelined_adder

Overview:
- Parametrised successor to the single-bit clocked half-adder top: a WIDTH-bit add/subtract unit built as a gate-level-pipelined ripple adder, modelling SFQ clocked-gate timing.
- Every bit slice is one clocked stage, and operands are skewed and de-skewed through register triangles.
- Configurable register stages model the PTL transmitter and receiver links on the input and output boundaries.
- It is the arithmetic core used by the SFQ datapath tops, and accepts one operation per clock.

Parameters:
- WIDTH, 4, operand/result width in bits (>=2)
- TX_STAGES, 1, input link register stages (PTL tx model, >=0)
- RX_STAGES, 1, output link register stages (PTL rx model, >=0)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand set valid this cycle
- a  input  WIDTH  operand A, two's complement or unsigned
- b  input  WIDTH  operand B
- sub  input  1  0: A+B; 1: A-B (A + ~B + 1), sampled with in_valid
- out_valid  output  1  result valid; single-cycle pulse per operation
- s  output  WIDTH  sum/difference
- cout  output  1  carry out of MSB (sub: 1 = no borrow)
- ovf  output  1  signed overflow, carry-into-MSB XOR carry-out-of-MSB

Behaviour:
- Reset (async assert, sync-safe release): all pipeline, valid, skew and output registers are cleared. Outputs are out_valid=0, s=0, cout=0, ovf=0. Every in-flight operation is discarded; nothing emerges after reset.
- Latency: L = TX_STAGES + WIDTH + RX_STAGES cycles from the in_valid sample edge to the out_valid assertion edge. WIDTH=4, TX=1, RX=1 gives L=6.
- Throughput: one operation per cycle with no backpressure. in_valid may be high every cycle, and each operation keeps its own sub bit.
- TX section: a, b, sub and in_valid pass through TX_STAGES plain registers. TX_STAGES=0 means a direct feed.
- Adder section, stage k (k=0..WIDTH-1), one cycle each:
  - Stage k registers bit k of the result and the carry into stage k+1.
  - Stage 0 carry-in equals sub, and b bits are XORed with the sub carried in that operation's pipeline slot.
  - Operand bits j>k are delayed alongside the operation (input skew triangle).
  - Result bits j<k are delayed alongside it (output de-skew triangle), so all WIDTH bits are aligned after stage WIDTH-1.
  - The carry into the MSB is retained in the final stage for the ovf computation.
- Valid tracking: a 1-bit valid travels with each operation through every stage. Bubbles (in_valid=0) propagate as valid=0.
- RX section: RX_STAGES registers for result, cout, ovf and valid.
- Output registers: s, cout and ovf update only on a cycle where the final valid is 1, and otherwise hold their last valid result. out_valid is 1 only for exactly that cycle per operation.
- Width rules:
  - Result is modulo 2^WIDTH.
  - cout is the raw carry of A + (B^{sub}) + sub.
  - ovf is valid for signed interpretation in both modes.
- Boundary cases:
  - All-ones plus one wraps to 0 with cout=1.
  - Subtract of equal operands gives 0 with cout=1, ovf=0.
  - Most-negative minus 1 sets ovf.
- Mixed add/sub streams: alternating sub values back-to-back must not cross-contaminate, because sub travels per slot.
- Reset mid-operation: asserting rst with k operations in flight clears all of them immediately. Outputs go to reset values within the same cycle (async). After release, the first out_valid appears exactly L cycles after the next accepted in_valid.
- No combinational path from any input to any output. All outputs are registered.

Test Plan (WIDTH=4, TX_STAGES=1, RX_STAGES=1, L=6):
- Reset then a=0111, b=0001, sub=0 at cycle 0 -> cycle 6: out_valid=1, s=1000, cout=0, ovf=1; out_valid=0 at cycles 5 and 7.
- a=1111, b=0001, sub=0 -> s=0000, cout=1, ovf=0 after 6 cycles; s holds 0000 while out_valid=0.
- a=0011, b=0101, sub=1 -> s=1110, cout=0, ovf=0; then a=1000, b=0001, sub=1 -> s=0111, cout=1, ovf=1.
- Back-to-back 16 cycles of random a/b/sub with in_valid=1 -> 16 consecutive out_valid cycles starting at cycle 6, each matching the reference model in order.
- Pattern valid,bubble,valid,valid -> out_valid pattern 1,0,1,1 starting at cycle 6, with s unchanged during the bubble.
- Issue 3 ops at cycles 0-2 and assert rst at cycle 3 for 1 cycle -> no out_valid ever appears for them. The next op issued at cycle 6 gives out_valid at cycle 12 with the correct result.
- Re-run the first scenario with TX_STAGES=0, RX_STAGES=0, WIDTH=8 (a=01111111, b=00000001) -> L=8, s=10000000, cout=0, ovf=1.

Source files
------------

// File: rtl/sfq_pipelined_adder.sv
// WIDTH-bit add/subtract unit built as a bit-level pipelined ripple adder (one clocked
// stage per bit) with register stages modelling the PTL links on both boundaries.
module sfq_pipelined_adder #(
   parameter int WIDTH     = 4,
   parameter int TX_STAGES = 1,
   parameter int RX_STAGES = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   logic [WIDTH-1:0] tx_a, tx_b;
   logic             tx_sub, tx_v;

   if (TX_STAGES == 0) begin : g_tx_direct
      assign tx_a   = a;
      assign tx_b   = b;
      assign tx_sub = sub;
      assign tx_v   = in_valid;
   end else begin : g_tx
      logic [TX_STAGES-1:0][WIDTH-1:0] a_q, b_q;
      logic [TX_STAGES-1:0]            sub_q, v_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            sub_q <= '0;
            v_q   <= '0;
         end else begin
            a_q[0]   <= a;
            b_q[0]   <= b;
            sub_q[0] <= sub;
            v_q[0]   <= in_valid;
            for (int i = 1; i < TX_STAGES; i++) begin
               a_q[i]   <= a_q[i-1];
               b_q[i]   <= b_q[i-1];
               sub_q[i] <= sub_q[i-1];
               v_q[i]   <= v_q[i-1];
            end
         end
      end

      assign tx_a   = a_q[TX_STAGES-1];
      assign tx_b   = b_q[TX_STAGES-1];
      assign tx_sub = sub_q[TX_STAGES-1];
      assign tx_v   = v_q[TX_STAGES-1];
   end

   // Stage gi consumes operand bit gi; bits above it ride along (skew triangle) and the
   // result bits already produced ride along below it (de-skew triangle).
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_st
      logic [WIDTH-1:gi] a_in, b_in;
      logic              sub_in, c_in, v_in;
      logic              bx, sum_d, c_d;
      logic [gi:0]       r_d, r_q;
      logic              c_q, v_q;

      if (gi == 0) begin : g_first
         assign a_in   = tx_a;
         assign b_in   = tx_b;
         assign sub_in = tx_sub;
         assign c_in   = tx_sub;
         assign v_in   = tx_v;
         assign r_d    = sum_d;
      end else begin : g_rest
         assign a_in   = g_st[gi-1].g_ops.a_q;
         assign b_in   = g_st[gi-1].g_ops.b_q;
         assign sub_in = g_st[gi-1].g_ops.sub_q;
         assign c_in   = g_st[gi-1].c_q;
         assign v_in   = g_st[gi-1].v_q;
         assign r_d    = {sum_d, g_st[gi-1].r_q};
      end

      assign bx    = b_in[gi] ^ sub_in;
      assign sum_d = a_in[gi] ^ bx ^ c_in;
      assign c_d   = (a_in[gi] & bx) | (c_in & (a_in[gi] ^ bx));

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_q <= '0;
            c_q <= 1'b0;
            v_q <= 1'b0;
         end else begin
            r_q <= r_d;
            c_q <= c_d;
            v_q <= v_in;
         end
      end

      if (gi < WIDTH-1) begin : g_ops
         logic [WIDTH-1:gi+1] a_q, b_q;
         logic                sub_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               a_q   <= '0;
               b_q   <= '0;
               sub_q <= 1'b0;
            end else begin
               a_q   <= a_in[WIDTH-1:gi+1];
               b_q   <= b_in[WIDTH-1:gi+1];
               sub_q <= sub_in;
            end
         end
      end else begin : g_last
         // Carry into the MSB, kept for the signed-overflow term.
         logic cmsb_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) cmsb_q <= 1'b0;
            else     cmsb_q <= c_in;
         end
      end
   end

   logic [WIDTH-1:0] add_s, fin_s;
   logic             add_c, add_o, add_v, fin_c, fin_o, fin_v;

   assign add_s = g_st[WIDTH-1].r_q;
   assign add_c = g_st[WIDTH-1].c_q;
   assign add_o = g_st[WIDTH-1].c_q ^ g_st[WIDTH-1].g_last.cmsb_q;
   assign add_v = g_st[WIDTH-1].v_q;

   if (RX_STAGES == 0) begin : g_rx_direct
      assign fin_s = add_s;
      assign fin_c = add_c;
      assign fin_o = add_o;
      assign fin_v = add_v;
   end else begin : g_rx
      logic [RX_STAGES-1:0][WIDTH-1:0] s_q;
      logic [RX_STAGES-1:0]            c_q, o_q, v_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            s_q <= '0;
            c_q <= '0;
            o_q <= '0;
            v_q <= '0;
         end else begin
            s_q[0] <= add_s;
            c_q[0] <= add_c;
            o_q[0] <= add_o;
            v_q[0] <= add_v;
            for (int i = 1; i < RX_STAGES; i++) begin
               s_q[i] <= s_q[i-1];
               c_q[i] <= c_q[i-1];
               o_q[i] <= o_q[i-1];
               v_q[i] <= v_q[i-1];
            end
         end
      end

      assign fin_s = s_q[RX_STAGES-1];
      assign fin_c = c_q[RX_STAGES-1];
      assign fin_o = o_q[RX_STAGES-1];
      assign fin_v = v_q[RX_STAGES-1];
   end

   logic [WIDTH-1:0] s_q;
   logic             out_valid_q, cout_q, ovf_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         s_q         <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         out_valid_q <= fin_v;
         if (fin_v) begin
            s_q    <= fin_s;
            cout_q <= fin_c;
            ovf_q  <= fin_o;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign s         = s_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_sfq_pipelined_adder.sv
// Self-checking bench for sfq_pipelined_adder: scoreboard of expected results keyed by
// the edge on which each result must appear, plus a second wide/zero-link instance.
module tb_sfq_pipelined_adder;

   localparam int W  = 4;
   localparam int L  = 6;
   localparam int L8 = 8;

   typedef struct {
      int           due;
      logic [W-1:0] s;
      logic         cout;
      logic         ovf;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0, sub = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic         out_valid, cout, ovf;
   logic [W-1:0] s;

   logic         iv8 = 1'b0, sub8 = 1'b0;
   logic [7:0]   a8 = '0, b8 = '0;
   logic         ov8, c8, o8;
   logic [7:0]   s8;

   int   edge_n = 0;
   int   total  = 0;
   int   bad    = 0;
   exp_t exp_q[$];
   exp_t last_e;

   sfq_pipelined_adder #(.WIDTH(W), .TX_STAGES(1), .RX_STAGES(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .sub(sub),
      .out_valid(out_valid), .s(s), .cout(cout), .ovf(ovf)
   );

   sfq_pipelined_adder #(.WIDTH(8), .TX_STAGES(0), .RX_STAGES(0)) dut8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .a(a8), .b(b8), .sub(sub8),
      .out_valid(ov8), .s(s8), .cout(c8), .ovf(o8)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_n <= edge_n + 1;

   function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xs);
      exp_t         e;
      logic [W-1:0] bb;
      logic [W:0]   full;
      bb     = xs ? ~xb : xb;
      full   = {1'b0, xa} + {1'b0, bb} + (W+1)'(xs);
      e.due  = 0;
      e.s    = full[W-1:0];
      e.cout = full[W];
      e.ovf  = (xa[W-1] == bb[W-1]) && (e.s[W-1] != xa[W-1]);
      return e;
   endfunction

   task automatic drive(input logic v, input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xs);
      exp_t e;
      in_valid = v;
      a        = xa;
      b        = xb;
      sub      = xs;
      if (v) begin
         e     = model(xa, xb, xs);
         e.due = edge_n + 1 + L;
         exp_q.push_back(e);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, '0, '0, 1'b0);
      repeat (2) @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || s !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
         bad++;
         $display("FAIL reset4 got v=%b s=%b c=%b o=%b want all zero", out_valid, s, cout, ovf);
      end
      total++;
      if (ov8 !== 1'b0 || s8 !== '0 || c8 !== 1'b0 || o8 !== 1'b0) begin
         bad++;
         $display("FAIL reset8 got v=%b s=%b c=%b o=%b want all zero", ov8, s8, c8, o8);
      end
      rst         = 1'b0;
      last_e.due  = 0;
      last_e.s    = '0;
      last_e.cout = 1'b0;
      last_e.ovf  = 1'b0;
   endtask

   // Isolated ops, 8 cycles apart, so each result and the hold in between are visible.
   task automatic test_directed();
      logic [W-1:0] ta[5] = '{4'b0111, 4'b1111, 4'b0011, 4'b1000, 4'b0101};
      logic [W-1:0] tb[5] = '{4'b0001, 4'b0001, 4'b0101, 4'b0001, 4'b0101};
      logic         ts[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      exp_t         e;
      for (int c = 0; c < 5 * 8 + 2; c++) begin
         @(negedge clk);
         total++;
         if (exp_q.size() != 0 && exp_q[0].due <= edge_n) begin
            e = exp_q.pop_front();
            if (out_valid !== 1'b1 || s !== e.s || cout !== e.cout || ovf !== e.ovf) begin
               bad++;
               $display("FAIL directed edge=%0d got v=%b s=%b c=%b o=%b want v=1 s=%b c=%b o=%b",
                        edge_n, out_valid, s, cout, ovf, e.s, e.cout, e.ovf);
            end
            $display("directed result edge=%0d s=%b cout=%b ovf=%b", edge_n, s, cout, ovf);
            last_e = e;
         end else if (out_valid !== 1'b0 || s !== last_e.s || cout !== last_e.cout || ovf !== last_e.ovf) begin
            bad++;
            $display("FAIL directed_hold edge=%0d got v=%b s=%b c=%b o=%b want v=0 s=%b c=%b o=%b",
                     edge_n, out_valid, s, cout, ovf, last_e.s, last_e.cout, last_e.ovf);
         end
         if (c % 8 == 0 && c / 8 < 5) drive(1'b1, ta[c/8], tb[c/8], ts[c/8]);
         else                         drive(1'b0, '0, '0, 1'b0);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      for (int c = 0; c < 16 + L + 2; c++) begin
         @(negedge clk);
         total++;
         if (exp_q.size() != 0 && exp_q[0].due <= edge_n) begin
            e = exp_q.pop_front();
            if (out_valid !== 1'b1 || s !== e.s || cout !== e.cout || ovf !== e.ovf) begin
               bad++;
               $display("FAIL b2b edge=%0d got v=%b s=%b c=%b o=%b want v=1 s=%b c=%b o=%b",
                        edge_n, out_valid, s, cout, ovf, e.s, e.cout, e.ovf);
            end
            $display("b2b result edge=%0d s=%b cout=%b ovf=%b", edge_n, s, cout, ovf);
            last_e = e;
         end else if (out_valid !== 1'b0 || s !== last_e.s || cout !== last_e.cout || ovf !== last_e.ovf) begin
            bad++;
            $display("FAIL b2b_hold edge=%0d got v=%b s=%b want v=0 s=%b", edge_n, out_valid, s, last_e.s);
         end
         if (c < 16) drive(1'b1, W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         else        drive(1'b0, '0, '0, 1'b0);
      end
   endtask

   task automatic test_bubbles();
      logic pat[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      exp_t e;
      for (int c = 0; c < 4 + L + 2; c++) begin
         @(negedge clk);
         total++;
         if (exp_q.size() != 0 && exp_q[0].due <= edge_n) begin
            e = exp_q.pop_front();
            if (out_valid !== 1'b1 || s !== e.s || cout !== e.cout || ovf !== e.ovf) begin
               bad++;
               $display("FAIL bubble edge=%0d got v=%b s=%b c=%b o=%b want v=1 s=%b c=%b o=%b",
                        edge_n, out_valid, s, cout, ovf, e.s, e.cout, e.ovf);
            end
            $display("bubble result edge=%0d s=%b cout=%b ovf=%b", edge_n, s, cout, ovf);
            last_e = e;
         end else if (out_valid !== 1'b0 || s !== last_e.s || cout !== last_e.cout || ovf !== last_e.ovf) begin
            bad++;
            $display("FAIL bubble_hold edge=%0d got v=%b s=%b want v=0 s=%b", edge_n, out_valid, s, last_e.s);
         end
         // Bubbles carry junk operands that must never surface.
         if (c < 4) drive(pat[c], W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         else       drive(1'b0, '0, '0, 1'b0);
      end
   endtask

   task automatic test_reset_midflight();
      exp_t e;
      for (int c = 0; c < 6 + L + 3; c++) begin
         @(negedge clk);
         total++;
         if (exp_q.size() != 0 && exp_q[0].due <= edge_n) begin
            e = exp_q.pop_front();
            if (out_valid !== 1'b1 || s !== e.s || cout !== e.cout || ovf !== e.ovf) begin
               bad++;
               $display("FAIL midrst edge=%0d got v=%b s=%b c=%b o=%b want v=1 s=%b c=%b o=%b",
                        edge_n, out_valid, s, cout, ovf, e.s, e.cout, e.ovf);
            end
            $display("midrst result edge=%0d s=%b cout=%b ovf=%b", edge_n, s, cout, ovf);
            last_e = e;
         end else if (out_valid !== 1'b0 || s !== last_e.s || cout !== last_e.cout || ovf !== last_e.ovf) begin
            bad++;
            $display("FAIL midrst_hold edge=%0d got v=%b s=%b want v=0 s=%b", edge_n, out_valid, s, last_e.s);
         end
         if (c < 3) begin
            drive(1'b1, W'(c + 5), 4'b0011, c[0]);
         end else if (c == 3) begin
            drive(1'b0, '0, '0, 1'b0);
            rst = 1'b1;
            #1;
            total++;
            if (out_valid !== 1'b0 || s !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
               bad++;
               $display("FAIL async_rst got v=%b s=%b c=%b o=%b want all zero", out_valid, s, cout, ovf);
            end
            exp_q.delete();
            last_e.s    = '0;
            last_e.cout = 1'b0;
            last_e.ovf  = 1'b0;
         end else if (c == 4) begin
            rst = 1'b0;
         end else if (c == 6) begin
            drive(1'b1, 4'b0110, 4'b0111, 1'b0);
         end else begin
            drive(1'b0, '0, '0, 1'b0);
         end
      end
   endtask

   task automatic test_wide();
      int due;
      @(negedge clk);
      iv8  = 1'b1;
      a8   = 8'b0111_1111;
      b8   = 8'b0000_0001;
      sub8 = 1'b0;
      due  = edge_n + 1 + L8;
      for (int c = 0; c < L8 + 4; c++) begin
         @(negedge clk);
         iv8 = 1'b0;
         total++;
         if (edge_n == due) begin
            if (ov8 !== 1'b1 || s8 !== 8'b1000_0000 || c8 !== 1'b0 || o8 !== 1'b1) begin
               bad++;
               $display("FAIL wide edge=%0d got v=%b s=%b c=%b o=%b want v=1 s=10000000 c=0 o=1",
                        edge_n, ov8, s8, c8, o8);
            end
            $display("wide result edge=%0d s=%b cout=%b ovf=%b", edge_n, s8, c8, o8);
         end else if (ov8 !== 1'b0) begin
            bad++;
            $display("FAIL wide_valid edge=%0d got v=%b want v=0", edge_n, ov8);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_bubbles();
      test_reset_midflight();
      test_wide();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
